// File: rtl/text_pixel_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : text_pixel_shifter
//  Description : Serializes one glyph scanline per character cell at the dot
//                clock. Applies fg/bg colour, underline, blanking and (when
//                built with TEXT_CURSOR_EN) a blinking cursor inversion.
//                Optional feature macro: TEXT_CURSOR_EN
//  Revision    : 1.0 - initial release
// ============================================================================
module text_pixel_shifter #(
   parameter int unsigned               pColorWidth = 24,
   parameter logic [pColorWidth-1:0]    pBlankColor = '0
) (
   input  logic                   dot_clk_i,
   input  logic                   rst_ni,
   input  logic                   ce_i,
   input  logic                   blank_i,
   input  logic [63:0]            bmp_i,
   input  logic [pColorWidth-1:0] fg_i,
   input  logic [pColorWidth-1:0] bg_i,
   input  logic                   ul_i,
   input  logic [5:0]             maxScanpix_i,
   input  logic [5:0]             scanline_i,
   input  logic [5:0]             ulScanline_i,
   input  logic                   cursor_i,
   input  logic                   vsync_i,
   input  logic [1:0]             cursor_mode_i,
   output logic [pColorWidth-1:0] color_o,
   output logic                   pix_o,
   output logic                   active_o
);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   state_t                 r_state, w_state_nxt;
   logic [63:0]            r_shift, w_shift_nxt;
   logic [6:0]             r_cnt, w_cnt_nxt;     // index of the next pixel to emit (0..64)
   logic [5:0]             r_last;               // sampled width minus one = tap index
   logic [pColorWidth-1:0] r_fg, r_bg;
   logic                   r_ul_hit;
   logic                   r_cursor;

   logic                   w_emit;
   logic                   w_glyph;
   logic                   w_ul;
   logic                   w_cur;
   logic                   w_pix;
   logic                   w_cursor_vis;
   logic [pColorWidth-1:0] w_fg, w_bg;

`ifdef TEXT_CURSOR_EN
   logic       r_vsync_d;
   logic [4:0] r_blink;

   // Blink timebase: count rising edges of vsync, wrapping naturally at 31
   always_ff @(posedge dot_clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_vsync_d <= 1'b0;
         r_blink   <= 5'd0;
      end else begin
         r_vsync_d <= vsync_i;
         if (vsync_i && !r_vsync_d)
            r_blink <= r_blink + 5'd1;
      end
   end

   // Cursor visibility decode from mode and blink phase
   always_comb begin
      w_cursor_vis = 1'b0;
      case (cursor_mode_i)
         2'b00:   w_cursor_vis = 1'b1;
         2'b01:   w_cursor_vis = 1'b0;
         2'b10:   w_cursor_vis = r_blink[4];
         default: w_cursor_vis = r_blink[3];
      endcase
   end
`else
   logic w_unused_cursor;
   assign w_cursor_vis    = 1'b0;
   assign w_unused_cursor = ^{vsync_i, cursor_mode_i};
`endif

   // State register
   always_ff @(posedge dot_clk_i or negedge rst_ni) begin
      if (!rst_ni)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // Next state and the pixel to present next cycle. A new cell always wins,
   // so its pixel 0 is taken straight from bmp_i and the shifter is loaded
   // already advanced by one position.
   always_comb begin
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_cnt_nxt   = r_cnt;
      w_emit      = 1'b0;
      w_glyph     = 1'b0;
      w_ul        = 1'b0;
      w_cur       = 1'b0;
      w_fg        = r_fg;
      w_bg        = r_bg;
      if (ce_i) begin
         w_state_nxt = ST_ACTIVE;
         w_emit      = 1'b1;
         w_glyph     = bmp_i[maxScanpix_i];
         w_ul        = ul_i && (scanline_i == ulScanline_i);
         w_cur       = cursor_i;
         w_fg        = fg_i;
         w_bg        = bg_i;
         w_shift_nxt = {bmp_i[62:0], 1'b0};
         w_cnt_nxt   = 7'd1;
      end else if ((r_state == ST_ACTIVE) && (r_cnt <= {1'b0, r_last})) begin
         w_emit      = 1'b1;
         w_glyph     = r_shift[r_last];
         w_ul        = r_ul_hit;
         w_cur       = r_cursor;
         w_shift_nxt = {r_shift[62:0], 1'b0};
         w_cnt_nxt   = r_cnt + 7'd1;
      end else begin
         w_state_nxt = ST_IDLE;
      end
      w_pix = w_emit & ((w_glyph | w_ul) ^ (w_cur & w_cursor_vis));
   end

   // Shifter, pixel counter and per-cell attributes captured on ce_i
   always_ff @(posedge dot_clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_shift  <= 64'd0;
         r_cnt    <= 7'd0;
         r_last   <= 6'd0;
         r_fg     <= '0;
         r_bg     <= '0;
         r_ul_hit <= 1'b0;
         r_cursor <= 1'b0;
      end else begin
         r_shift <= w_shift_nxt;
         r_cnt   <= w_cnt_nxt;
         if (ce_i) begin
            r_last   <= maxScanpix_i;
            r_fg     <= fg_i;
            r_bg     <= bg_i;
            r_ul_hit <= w_ul;
            r_cursor <= cursor_i;
         end
      end
   end

   // Registered outputs; blanking masks colour and pixel but not activity
   always_ff @(posedge dot_clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         color_o  <= pBlankColor;
         pix_o    <= 1'b0;
         active_o <= 1'b0;
      end else begin
         active_o <= w_emit;
         pix_o    <= w_pix & ~blank_i;
         if (!w_emit || blank_i)
            color_o <= pBlankColor;
         else
            color_o <= w_pix ? w_fg : w_bg;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_text_pixel_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_text_pixel_shifter
//  Description : Directed self-checking bench for text_pixel_shifter.
//                Cursor cases follow the TEXT_CURSOR_EN build setting.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_text_pixel_shifter;

   logic        clk;
   logic        rst_n;
   logic        ce;
   logic        blank;
   logic [63:0] bmp;
   logic [23:0] fg;
   logic [23:0] bg;
   logic        ul;
   logic [5:0]  max_pix;
   logic [5:0]  scanline;
   logic [5:0]  ul_scanline;
   logic        cursor;
   logic        vsync;
   logic [1:0]  cursor_mode;
   logic [23:0] color;
   logic        pix;
   logic        active;

   int n_checks = 0;
   int n_errors = 0;

   text_pixel_shifter #(
      .pColorWidth (24),
      .pBlankColor (24'h000000)
   ) dut (
      .dot_clk_i     (clk),
      .rst_ni        (rst_n),
      .ce_i          (ce),
      .blank_i       (blank),
      .bmp_i         (bmp),
      .fg_i          (fg),
      .bg_i          (bg),
      .ul_i          (ul),
      .maxScanpix_i  (max_pix),
      .scanline_i    (scanline),
      .ulScanline_i  (ul_scanline),
      .cursor_i      (cursor),
      .vsync_i       (vsync),
      .cursor_mode_i (cursor_mode),
      .color_o       (color),
      .pix_o         (pix),
      .active_o      (active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_active"}, 64'(active), 64'd0);
      check({tag, "_color"},  64'(color),  64'd0);
      check({tag, "_pix"},    64'(pix),    64'd0);
   endtask

   task automatic load(input logic [63:0] b, input logic [5:0] last,
                       input logic [23:0] f, input logic [23:0] g, input logic u,
                       input logic [5:0] sl, input logic [5:0] usl, input logic cur);
      ce = 1'b1; bmp = b; max_pix = last; fg = f; bg = g; ul = u;
      scanline = sl; ul_scanline = usl; cursor = cur;
   endtask

   // Checks nshow pixels of a cell starting at pixel 0; leaves time at the
   // last checked pixel so the caller can load a follow-on cell there.
   // Cell inputs are scrambled so any non-sampled use of them shows up.
   task automatic expect_cell(input string tag, input logic [63:0] bits, input logic [5:0] last,
                              input int nshow, input logic force1,
                              input logic [23:0] efg, input logic [23:0] ebg);
      logic [63:0] b;
      logic [5:0]  idx;
      logic        p;
      b  = bits;
      ce = 1'b0; bmp = 64'hDEAD_BEEF_0BAD_F00D; fg = 24'h5A5A5A; bg = 24'hA5A5A5;
      ul = 1'b1; scanline = 6'd0; ul_scanline = 6'd0; max_pix = 6'd63; cursor = 1'b1;
      for (int k = 0; k < nshow; k++) begin
         idx = last - 6'(k);
         p   = b[idx] | force1;
         check($sformatf("%s_pix%0d", tag, k),    64'(pix),    64'(p));
         check($sformatf("%s_color%0d", tag, k),  64'(color),  64'(p ? efg : ebg));
         check($sformatf("%s_active%0d", tag, k), 64'(active), 64'd1);
         if (k < nshow - 1) tick();
      end
   endtask

   initial begin
      logic [63:0] a5;
      logic [4:0]  blink_cnt;
      a5 = 64'h0A5;
      blink_cnt = 5'd0;
      rst_n = 1'b0; ce = 1'b0; blank = 1'b0; bmp = '0; fg = '0; bg = '0; ul = 1'b0;
      max_pix = '0; scanline = '0; ul_scanline = '0; cursor = 1'b0; vsync = 1'b0;
      cursor_mode = 2'b00;
      repeat (3) tick();
      #1; check_idle("in_reset");
      rst_n = 1'b1;
      tick();
      check_idle("reset");

      // asynchronous reset in the middle of a cell
      load(64'hFF, 6'd7, 24'hFFFFFF, 24'h000000, 1'b0, 6'd0, 6'd1, 1'b0);
      tick();
      expect_cell("pre_rst", 64'hFF, 6'd7, 2, 1'b0, 24'hFFFFFF, 24'h000000);
      #2 rst_n = 1'b0;
      #1 check_idle("async_rst");
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (3) begin
         tick();
         check_idle("post_rst");
      end

      // basic 8-pixel cell
      load(a5, 6'd7, 24'hFFFFFF, 24'h000000, 1'b0, 6'd0, 6'd1, 1'b0);
      tick();
      expect_cell("a5", a5, 6'd7, 8, 1'b0, 24'hFFFFFF, 24'h000000);
      tick();
      check_idle("a5_end");

      // bits above the sampled width must be ignored
      load(64'hFFFF_FFFF_FFFF_FFF5, 6'd3, 24'h123456, 24'h654321, 1'b0, 6'd0, 6'd1, 1'b0);
      tick();
      expect_cell("tap", 64'hFFFF_FFFF_FFFF_FFF5, 6'd3, 4, 1'b0, 24'h123456, 24'h654321);
      tick();
      check_idle("tap_end");

      // back-to-back, then a truncated cell, then a full one
      load(64'hF0, 6'd7, 24'h111111, 24'h222222, 1'b0, 6'd0, 6'd1, 1'b0);
      tick();
      expect_cell("b2b_a", 64'hF0, 6'd7, 8, 1'b0, 24'h111111, 24'h222222);
      load(64'h0F, 6'd7, 24'h333333, 24'h444444, 1'b0, 6'd0, 6'd1, 1'b0);
      tick();
      expect_cell("b2b_b", 64'h0F, 6'd7, 8, 1'b0, 24'h333333, 24'h444444);
      load(64'h96, 6'd7, 24'h555555, 24'h666666, 1'b0, 6'd0, 6'd1, 1'b0);
      tick();
      expect_cell("trunc", 64'h96, 6'd7, 5, 1'b0, 24'h555555, 24'h666666);
      load(64'h3C, 6'd7, 24'h777777, 24'h888888, 1'b0, 6'd0, 6'd1, 1'b0);
      tick();
      expect_cell("after_trunc", 64'h3C, 6'd7, 8, 1'b0, 24'h777777, 24'h888888);
      tick();
      check_idle("b2b_end");

      // width 64
      load(64'hC000_0000_0000_0005, 6'd63, 24'hABCDEF, 24'h010203, 1'b0, 6'd0, 6'd1, 1'b0);
      tick();
      expect_cell("w64", 64'hC000_0000_0000_0005, 6'd63, 64, 1'b0, 24'hABCDEF, 24'h010203);
      tick();
      check_idle("w64_end");

      // width 1, two cells back to back
      load(64'h1, 6'd0, 24'h0000FF, 24'h00FF00, 1'b0, 6'd0, 6'd1, 1'b0);
      tick();
      expect_cell("w1_a", 64'h1, 6'd0, 1, 1'b0, 24'h0000FF, 24'h00FF00);
      load(64'h2, 6'd0, 24'h0000FF, 24'h00FF00, 1'b0, 6'd0, 6'd1, 1'b0);
      tick();
      expect_cell("w1_b", 64'h2, 6'd0, 1, 1'b0, 24'h0000FF, 24'h00FF00);
      tick();
      check_idle("w1_end");

      // underline on matching scanline, then on a non-matching one
      load(64'h0, 6'd11, 24'hF0F0F0, 24'h0F0F0F, 1'b1, 6'd15, 6'd15, 1'b0);
      tick();
      expect_cell("ul_on", 64'h0, 6'd11, 12, 1'b1, 24'hF0F0F0, 24'h0F0F0F);
      tick();
      check_idle("ul_on_end");
      load(64'h0, 6'd11, 24'hF0F0F0, 24'h0F0F0F, 1'b1, 6'd14, 6'd15, 1'b0);
      tick();
      expect_cell("ul_off", 64'h0, 6'd11, 12, 1'b0, 24'hF0F0F0, 24'h0F0F0F);
      tick();
      check_idle("ul_off_end");

      // blank_i during cycles N+3..N+4 masks pixels 3 and 4
      load(a5, 6'd7, 24'hFFFFFF, 24'h202020, 1'b0, 6'd0, 6'd1, 1'b0);
      tick();
      ce = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (k == 3 || k == 4) begin
            check($sformatf("blank_pix%0d", k),   64'(pix),   64'd0);
            check($sformatf("blank_color%0d", k), 64'(color), 64'd0);
         end else begin
            check($sformatf("blank_pix%0d", k),   64'(pix),   64'(a5[7-k]));
            check($sformatf("blank_color%0d", k), 64'(color),
                  64'(a5[7-k] ? 24'hFFFFFF : 24'h202020));
         end
         check($sformatf("blank_active%0d", k), 64'(active), 64'd1);
         blank = (k == 2 || k == 3);
         tick();
      end
      blank = 1'b0;
      check_idle("blank_end");

`ifdef TEXT_CURSOR_EN
      // fast blink follows bit 3 of the vsync edge count
      cursor_mode = 2'b11;
      for (int v = 0; v < 16; v++) begin
         vsync = 1'b1; tick();
         vsync = 1'b0; tick();
         blink_cnt = blink_cnt + 5'd1;
         load(64'h0, 6'd3, 24'hFFFFFF, 24'h000000, 1'b0, 6'd0, 6'd1, 1'b1);
         tick();
         expect_cell($sformatf("cur_fast%0d", v), 64'h0, 6'd3, 4, blink_cnt[3],
                     24'hFFFFFF, 24'h000000);
         tick();
      end
      check_idle("cur_fast_end");
      // mode 01 never shows the cursor
      cursor_mode = 2'b01;
      load(64'h0, 6'd3, 24'hFFFFFF, 24'h000000, 1'b0, 6'd0, 6'd1, 1'b1);
      tick();
      expect_cell("cur_off", 64'h0, 6'd3, 4, 1'b0, 24'hFFFFFF, 24'h000000);
      tick();
      // slow blink with count 16: bit 4 set, visible
      cursor_mode = 2'b10;
      load(64'h0, 6'd3, 24'hFFFFFF, 24'h000000, 1'b0, 6'd0, 6'd1, 1'b1);
      tick();
      expect_cell("cur_slow", 64'h0, 6'd3, 4, 1'b1, 24'hFFFFFF, 24'h000000);
      tick();
      // steady cursor inverts a real glyph
      cursor_mode = 2'b00;
      load(a5, 6'd7, 24'hFFFFFF, 24'h000000, 1'b0, 6'd0, 6'd1, 1'b1);
      tick();
      expect_cell("cur_steady", ~a5, 6'd7, 8, 1'b0, 24'hFFFFFF, 24'h000000);
      tick();
      check_idle("cur_end");
`else
      // without the cursor feature cursor_i has no effect
      cursor_mode = 2'b00;
      vsync = 1'b1; tick();
      vsync = 1'b0; tick();
      load(a5, 6'd7, 24'hFFFFFF, 24'h000000, 1'b0, 6'd0, 6'd1, 1'b1);
      tick();
      expect_cell("no_cursor", a5, 6'd7, 8, 1'b0, 24'hFFFFFF, 24'h000000);
      tick();
      check_idle("no_cursor_end");
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
